// File: rtl/ucie_ctl_sb_rx_pkt_assembler.sv
// Sideband RX packet assembler: packs N-bit lane chunks LSB-first into a 64-bit header and optional 64-bit payload.
// Parity checking is built only when UCIE_CTL_SB_PARITY_CHECK_EN is defined.
module ucie_ctl_sb_rx_pkt_assembler #(
    parameter int unsigned N = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_chunk,
    input  logic         i_chunk_valid,
    output logic         o_chunk_ready,
    input  logic         i_flush,
    output logic [63:0]  o_hdr,
    output logic [63:0]  o_data,
    output logic         o_has_data,
    output logic         o_parity_err,
    output logic         o_pkt_valid,
    input  logic         i_pkt_ready
);

    localparam int unsigned CPW      = 32 / N;
    localparam logic [5:0]  CNT_LAST = 6'(CPW - 1);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA0,
        S_DATA1,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [63:0] hdr_q, hdr_d;
    logic [63:0] data_q, data_d;
    logic        has_data_q, has_data_d;
    logic        pkt_valid_q, pkt_valid_d;

    logic        accept;
    logic        word_done;
    logic [31:0] word_full;
    logic        clear_pkt;
    logic        enter_hold;

    always_comb begin
        accept    = i_chunk_valid && !pkt_valid_q;
        word_done = accept && (cnt_q == CNT_LAST);
        // Completed word includes the chunk arriving this cycle so it can be committed on the same edge.
        word_full = word_q;
        for (int unsigned i = 0; i < CPW; i++) begin
            if (cnt_q == 6'(i)) begin
                word_full[i*N +: N] = i_chunk;
            end
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        hdr_d       = hdr_q;
        data_d      = data_q;
        has_data_d  = has_data_q;
        pkt_valid_d = pkt_valid_q;
        clear_pkt   = 1'b0;
        enter_hold  = 1'b0;

        if (i_flush || ((state_q == S_HOLD) && i_pkt_ready)) begin
            clear_pkt   = 1'b1;
            state_d     = S_HDR0;
            cnt_d       = '0;
            word_d      = '0;
            data_d      = '0;
            has_data_d  = 1'b0;
            pkt_valid_d = 1'b0;
        end else if (accept) begin
            word_d = word_full;
            cnt_d  = word_done ? '0 : cnt_q + 6'd1;
            if (word_done) begin
                case (state_q)
                    S_HDR0: begin
                        hdr_d[31:0] = word_full;
                        state_d     = S_HDR1;
                    end
                    S_HDR1: begin
                        hdr_d[63:32] = word_full;
                        has_data_d   = hdr_q[0];
                        if (hdr_q[0]) begin
                            state_d = S_DATA0;
                        end else begin
                            state_d    = S_HOLD;
                            enter_hold = 1'b1;
                        end
                    end
                    S_DATA0: begin
                        data_d[31:0] = word_full;
                        state_d      = S_DATA1;
                    end
                    S_DATA1: begin
                        data_d[63:32] = word_full;
                        state_d       = S_HOLD;
                        enter_hold    = 1'b1;
                    end
                    default: state_d = S_HDR0;
                endcase
            end
        end

        if (enter_hold) begin
            pkt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_HDR0;
            cnt_q       <= '0;
            word_q      <= '0;
            hdr_q       <= '0;
            data_q      <= '0;
            has_data_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            hdr_q       <= hdr_d;
            data_q      <= data_d;
            has_data_q  <= has_data_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

`ifdef UCIE_CTL_SB_PARITY_CHECK_EN
    logic perr_q, perr_d;

    // Evaluated on the final header/payload values being committed as the packet enters HOLD.
    always_comb begin
        perr_d = perr_q;
        if (clear_pkt) begin
            perr_d = 1'b0;
        end else if (enter_hold) begin
            perr_d = (hdr_d[62] != ^hdr_d[61:0]) ||
                     (has_data_d && (hdr_d[63] != ^data_d));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_hdr         = hdr_q;
    assign o_data        = data_q;
    assign o_has_data    = has_data_q;
    assign o_pkt_valid   = pkt_valid_q;
    assign o_chunk_ready = !pkt_valid_q;

endmodule

// File: tb/tb_ucie_ctl_sb_rx_pkt_assembler.sv
// Directed bench for ucie_ctl_sb_rx_pkt_assembler with N=16, N=8 and N=4 instances.
module tb_ucie_ctl_sb_rx_pkt_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cv [3];
    logic        fl [3];
    logic        rdy[3];
    logic [15:0] ch16;
    logic [7:0]  ch8;
    logic [3:0]  ch4;
    logic [63:0] hdr[3];
    logic [63:0] dat[3];
    logic        hd [3];
    logic        pe [3];
    logic        pv [3];
    logic        cr [3];

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] H1  = 64'h4000_0000_0000_0010;
    localparam logic [63:0] H2  = 64'h4000_0000_0000_0001;
    localparam logic [63:0] D2  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D3  = 64'hDEAD_BEEF_0123_4566;
    localparam logic [63:0] H4  = 64'h0000_0000_0000_0110;
    localparam logic [63:0] HA  = 64'h1111_2222_3333_4444;
`ifdef UCIE_CTL_SB_PARITY_CHECK_EN
    localparam logic        PE3 = 1'b1;
`else
    localparam logic        PE3 = 1'b0;
`endif

    ucie_ctl_sb_rx_pkt_assembler #(.N(16)) u_n16 (
        .i_clk(clk), .i_reset(rst_n), .i_chunk(ch16), .i_chunk_valid(cv[0]),
        .o_chunk_ready(cr[0]), .i_flush(fl[0]), .o_hdr(hdr[0]), .o_data(dat[0]),
        .o_has_data(hd[0]), .o_parity_err(pe[0]), .o_pkt_valid(pv[0]), .i_pkt_ready(rdy[0])
    );
    ucie_ctl_sb_rx_pkt_assembler #(.N(8)) u_n8 (
        .i_clk(clk), .i_reset(rst_n), .i_chunk(ch8), .i_chunk_valid(cv[1]),
        .o_chunk_ready(cr[1]), .i_flush(fl[1]), .o_hdr(hdr[1]), .o_data(dat[1]),
        .o_has_data(hd[1]), .o_parity_err(pe[1]), .o_pkt_valid(pv[1]), .i_pkt_ready(rdy[1])
    );
    ucie_ctl_sb_rx_pkt_assembler #(.N(4)) u_n4 (
        .i_clk(clk), .i_reset(rst_n), .i_chunk(ch4), .i_chunk_valid(cv[2]),
        .o_chunk_ready(cr[2]), .i_flush(fl[2]), .o_hdr(hdr[2]), .o_data(dat[2]),
        .o_has_data(hd[2]), .o_parity_err(pe[2]), .o_pkt_valid(pv[2]), .i_pkt_ready(rdy[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives chunks [first, first+count) of the LSB-first stream {data, hdr}.
    task automatic send_chunks(input int d, input logic [127:0] stream, input int first, input int count);
        int n;
        logic [127:0] s;
        n = (d == 0) ? 16 : (d == 1) ? 8 : 4;
        for (int k = first; k < first + count; k++) begin
            s = stream >> (k * n);
            case (d)
                0:       ch16 = s[15:0];
                1:       ch8  = s[7:0];
                default: ch4  = s[3:0];
            endcase
            cv[d] = 1'b1;
            @(posedge clk);
            #1;
        end
        cv[d] = 1'b0;
    endtask

    task automatic take_pkt(input int d);
        rdy[d] = 1'b1;
        @(posedge clk);
        #1;
        rdy[d] = 1'b0;
        chk($sformatf("take%0d_pv", d), 64'(pv[d]), 64'd0);
        chk($sformatf("take%0d_cr", d), 64'(cr[d]), 64'd1);
        chk($sformatf("take%0d_dat", d), dat[d], 64'd0);
        chk($sformatf("take%0d_hd", d), 64'(hd[d]), 64'd0);
        chk($sformatf("take%0d_pe", d), 64'(pe[d]), 64'd0);
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk($sformatf("%s%0d_hdr", tag, d), hdr[d], 64'd0);
        chk($sformatf("%s%0d_dat", tag, d), dat[d], 64'd0);
        chk($sformatf("%s%0d_hd", tag, d), 64'(hd[d]), 64'd0);
        chk($sformatf("%s%0d_pe", tag, d), 64'(pe[d]), 64'd0);
        chk($sformatf("%s%0d_pv", tag, d), 64'(pv[d]), 64'd0);
        chk($sformatf("%s%0d_cr", tag, d), 64'(cr[d]), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ch16  = '0;
        ch8   = '0;
        ch4   = '0;
        for (int i = 0; i < 3; i++) begin
            cv[i]  = 1'b0;
            fl[i]  = 1'b0;
            rdy[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) chk_reset(i, "rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // N=16 header-only packet
        send_chunks(0, {64'd0, H1}, 0, 3);
        chk("t1_pv_early", 64'(pv[0]), 64'd0);
        chk("t1_cr_early", 64'(cr[0]), 64'd1);
        send_chunks(0, {64'd0, H1}, 3, 1);
        chk("t1_pv", 64'(pv[0]), 64'd1);
        chk("t1_cr", 64'(cr[0]), 64'd0);
        chk("t1_hdr", hdr[0], H1);
        chk("t1_hd", 64'(hd[0]), 64'd0);
        chk("t1_dat", dat[0], 64'd0);
        chk("t1_pe", 64'(pe[0]), 64'd0);
        take_pkt(0);

        // N=8 packet with payload, correct parity
        send_chunks(1, {D2, H2}, 0, 15);
        chk("t2_pv_early", 64'(pv[1]), 64'd0);
        send_chunks(1, {D2, H2}, 15, 1);
        chk("t2_pv", 64'(pv[1]), 64'd1);
        chk("t2_hdr", hdr[1], H2);
        chk("t2_hd", 64'(hd[1]), 64'd1);
        chk("t2_dat", dat[1], D2);
        chk("t2_pe", 64'(pe[1]), 64'd0);
        take_pkt(1);

        // N=8 payload with data bit 0 flipped
        send_chunks(1, {D3, H2}, 0, 16);
        chk("t3_pv", 64'(pv[1]), 64'd1);
        chk("t3_dat", dat[1], D3);
        chk("t3_hd", 64'(hd[1]), 64'd1);
        chk("t3_pe", 64'(pe[1]), 64'(PE3));

        // Backpressure with chunks offered
        cv[1] = 1'b1;
        ch8   = 8'hA5;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t4_cr_c%0d", c), 64'(cr[1]), 64'd0);
            chk($sformatf("t4_pv_c%0d", c), 64'(pv[1]), 64'd1);
        end
        chk("t4_hdr", hdr[1], H2);
        chk("t4_dat", dat[1], D3);
        chk("t4_pe", 64'(pe[1]), 64'(PE3));
        cv[1] = 1'b0;
        take_pkt(1);
        send_chunks(1, {64'd0, H4}, 0, 8);
        chk("t4n_pv", 64'(pv[1]), 64'd1);
        chk("t4n_hdr", hdr[1], H4);
        chk("t4n_hd", 64'(hd[1]), 64'd0);
        chk("t4n_dat", dat[1], 64'd0);
        chk("t4n_pe", 64'(pe[1]), 64'd0);
        take_pkt(1);

        // Flush after 3 of 4 header chunks, coincident with a valid chunk
        send_chunks(0, {64'd0, HA}, 0, 3);
        ch16  = 16'hAAAA;
        cv[0] = 1'b1;
        fl[0] = 1'b1;
        @(posedge clk);
        #1;
        cv[0] = 1'b0;
        fl[0] = 1'b0;
        chk("t5_pv_flush", 64'(pv[0]), 64'd0);
        chk("t5_cr_flush", 64'(cr[0]), 64'd1);
        chk("t5_hdr_kept", hdr[0], 64'h4000_0000_3333_4444);
        send_chunks(0, {64'd0, H4}, 0, 3);
        chk("t5_pv_early", 64'(pv[0]), 64'd0);
        send_chunks(0, {64'd0, H4}, 3, 1);
        chk("t5_pv", 64'(pv[0]), 64'd1);
        chk("t5_hdr", hdr[0], H4);
        chk("t5_pe", 64'(pe[0]), 64'd0);
        take_pkt(0);

        // N=4 asynchronous reset in the middle of DATA0
        send_chunks(2, {D2, H2}, 0, 19);
        chk("t6_pv_mid", 64'(pv[2]), 64'd0);
        chk("t6_hdr_mid", hdr[2], H2);
        chk("t6_hd_mid", 64'(hd[2]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(2, "t6rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_chunks(2, {D2, H2}, 0, 31);
        chk("t6_pv_early", 64'(pv[2]), 64'd0);
        send_chunks(2, {D2, H2}, 31, 1);
        chk("t6_pv", 64'(pv[2]), 64'd1);
        chk("t6_hdr", hdr[2], H2);
        chk("t6_dat", dat[2], D2);
        chk("t6_hd", 64'(hd[2]), 64'd1);
        chk("t6_pe", 64'(pe[2]), 64'd0);
        take_pkt(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_sb_rx_pkt_assembler.md
# ucie_ctl_sb_rx_pkt_assembler

Sideband receive packet assembler for the UCIe controller. It accepts N-bit deserialized chunks from the sideband RX lane logic and packs them LSB-first into 32-bit words. It builds a 64-bit header and, when the opcode carries data, a 64-bit payload. It presents the completed packet, with parity status, to the sideband message decoder over a valid/ready handshake.

## Interface
Parameters:
- N, 16, chunk width in bits; legal values 1, 2, 4, 8, 16, 32 (must divide 32)

Ports:
- i_clk  input  1  clock
- i_reset  input  1  reset, asynchronous, active-low
- i_chunk  input  N  received chunk; bit 0 is the earliest bit on the lane
- i_chunk_valid  input  1  i_chunk is valid this cycle
- o_chunk_ready  output  1  block can accept a chunk this cycle
- i_flush  input  1  synchronous discard of any partial packet
- o_hdr  output  64  assembled header
- o_data  output  64  assembled payload; 0 when o_has_data=0
- o_has_data  output  1  packet carries a 64-bit payload
- o_parity_err  output  1  control or data parity mismatch on the presented packet
- o_pkt_valid  output  1  packet on o_hdr/o_data is valid
- i_pkt_ready  input  1  decoder accepts the packet

## Operation
- Chunk accepted when i_chunk_valid && o_chunk_ready.
- o_chunk_ready = !o_pkt_valid.
- Chunk counter: 6 bits, range 0..32/N-1.
  - Increments on each accepted chunk.
  - Wraps to 0 on the last chunk of a word, which completes the word.
- Word shift register: 32 bits.
  - An accepted chunk is written to bits [cnt*N +: N].
  - A completed word is committed to the word slot selected by the state.
- States:
  - HDR0: completed word goes to o_hdr[31:0]; next state HDR1.
  - HDR1: completed word goes to o_hdr[63:32]. Decode opcode = hdr[4:0] and set has_data = opcode[0]. Next state is DATA0 if has_data, else HOLD.
  - DATA0: completed word goes to o_data[31:0]; next state DATA1.
  - DATA1: completed word goes to o_data[63:32]; next state HOLD.
  - HOLD: o_pkt_valid=1 and outputs are stable. When i_pkt_ready=1, go to HDR0 and clear o_data, o_has_data and o_parity_err.
- Parity:
  - Control parity: hdr[62] must equal ^hdr[61:0].
  - Data parity: hdr[63] must equal ^data[63:0], checked only if has_data.
  - o_parity_err is set on entry to HOLD.
  - A packet with a parity error is still delivered; the decoder drops it.
- i_flush:
  - Return to HDR0, clear the chunk counter, o_data, o_has_data, o_pkt_valid and o_parity_err. o_hdr is left unchanged.
  - Has priority over a simultaneous chunk; that chunk is dropped.
  - Also discards a packet held in HOLD.

## Timing
- Reset values: o_hdr=0, o_data=0, o_has_data=0, o_parity_err=0, o_pkt_valid=0, o_chunk_ready=1. State HDR0, counter 0.
- Reset asserted mid-packet discards all partial state immediately (asynchronous).
- Latency: o_pkt_valid rises on the clock edge that accepts the last chunk of the last word. It is visible the cycle after that chunk was presented.
- Packet length in accepted chunks: 64/N without payload, 128/N with payload.
- Handshake:
  - Transfer occurs on a cycle with o_pkt_valid && i_pkt_ready.
  - o_pkt_valid drops on the next edge.
  - o_chunk_ready rises in the same cycle o_pkt_valid drops.
  - Minimum one idle chunk slot between packets.
- o_pkt_valid stays high, with all outputs stable, for any number of cycles while i_pkt_ready=0.
- Gaps in i_chunk_valid are allowed anywhere; the counter and state hold during gaps.
- N=32: each accepted chunk is one word and the counter stays 0.

## Configuration
- Macro: UCIE_CTL_SB_PARITY_CHECK_EN.
- Defined: parity is checked as described in Operation.
- Not defined: o_parity_err is tied 0 and no parity XOR logic is built. Header bits 62/63 pass through unchecked.

## Test plan
- N=16, header-only packet hdr=64'h4000_0000_0000_0010 (opcode 5'h10, CP correct), 4 back-to-back chunks -> o_pkt_valid one cycle after the 4th chunk, o_has_data=0, o_data=0, o_parity_err=0.
- N=8, opcode 5'h01 header with data=64'hDEAD_BEEF_0123_4567 and correct CP/DP, 16 chunks -> o_has_data=1, o_data matches, o_parity_err=0.
- Same as the previous scenario with data bit 0 flipped (macro defined) -> o_parity_err=1 and the packet is still delivered. With the macro undefined -> o_parity_err=0.
- Hold i_pkt_ready=0 for 10 cycles while i_chunk_valid=1 -> o_chunk_ready=0, no chunk consumed, outputs stable. Assert i_pkt_ready -> o_pkt_valid falls and the next packet assembles correctly.
- After 3 of 4 header chunks, pulse i_flush coincident with a valid chunk, then send a fresh 4-chunk header -> the first packet is discarded and only the fresh header is presented.
- Assert i_reset low mid-DATA0 at N=4 -> all outputs at reset values, o_chunk_ready=1, and the next packet assembles from the HDR0 state.
